// File: rtl/nco_pkg.sv
// Shared framing constants for the NCO phase serializer/deserializer pair.
// Both ends import this package so slot count and widths stay in agreement.
package nco_pkg;

   localparam int CHUNK_W   = 2;                  // bits carried per slot
   localparam int NSLOT     = 6;                  // data slots per frame
   localparam int OUT_W     = CHUNK_W * NSLOT;    // reassembled phase word width
   localparam int FRAME_LEN = NSLOT + 1;          // strobe cycle plus data slots
   localparam int SLOT_W    = $clog2(NSLOT);

   typedef logic [1:0]        state_t;
   typedef logic [SLOT_W-1:0] slot_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_HUNT  = 2'd1;
   localparam state_t ST_RECV  = 2'd2;
   localparam state_t ST_CHECK = 2'd3;

   localparam slot_t LAST_SLOT = slot_t'(NSLOT - 1);

endpackage

// File: rtl/nco_chunk_shreg.sv
// Chunk-in / word-out shift register. Chunks enter at the MSB end so the
// first-received (LSB) pair ends up at bit 0 after NSLOT shifts.
module nco_chunk_shreg
   import nco_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_shift,
   input  logic [CHUNK_W-1:0] i_chunk,
   output logic [OUT_W-1:0]   o_word_nxt
);

   logic [OUT_W-1:0] r_word;
   logic [OUT_W-1:0] w_word_nxt;

   assign w_word_nxt = {i_chunk, r_word[OUT_W-1:CHUNK_W]};
   // Look-ahead value lets the owner capture the word on the closing edge.
   assign o_word_nxt = w_word_nxt;

   // Clear wins over shift so a resync always starts from an empty word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word <= '0;
      end else if (i_clr) begin
         r_word <= '0;
      end else if (i_shift) begin
         r_word <= w_word_nxt;
      end
   end

endmodule

// File: rtl/nco_phase_deserializer.sv
// Receive side of the NCO phase link: rebuilds the quadrant-folded phase
// word and its sign from the 2-bit chunk stream, tracks frame alignment and
// flags framing loss, resynchronising on the next strobe.
module nco_phase_deserializer
   import nco_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               En,
   input  logic               Vld_in,
   input  logic [CHUNK_W-1:0] Ain,
   input  logic               ISin,
   output logic [OUT_W-1:0]   Dout,
   output logic               Sout,
   output logic               Dvld,
   output logic               FrmErr,
   output logic               Locked
);

   state_t           r_state;
   state_t           w_state_nxt;
   slot_t            r_slot;
   slot_t            w_slot_nxt;
   logic             r_sign_hold;
   logic             w_sign_nxt;
   logic             w_clr;
   logic             w_shift;
   logic             w_load;
   logic             w_dvld_nxt;
   logic             w_frmerr_nxt;
   logic             w_locked_nxt;
   logic [OUT_W-1:0] w_word_nxt;

   nco_chunk_shreg u_shreg (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_shift    (w_shift),
      .i_chunk    (Ain),
      .o_word_nxt (w_word_nxt)
   );

   // Frame FSM: decides next state, slot, flags and shift-register controls.
   always_comb begin
      w_state_nxt  = r_state;
      w_slot_nxt   = r_slot;
      w_sign_nxt   = r_sign_hold;
      w_clr        = 1'b0;
      w_shift      = 1'b0;
      w_load       = 1'b0;
      w_dvld_nxt   = 1'b0;
      w_frmerr_nxt = 1'b0;
      w_locked_nxt = Locked;

      if (!En) begin
         // Disable drops any partial frame silently.
         w_state_nxt  = ST_IDLE;
         w_slot_nxt   = '0;
         w_clr        = 1'b1;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_HUNT;
            end
            ST_HUNT: begin
               if (Vld_in) begin
                  w_sign_nxt  = ISin;
                  w_slot_nxt  = '0;
                  w_clr       = 1'b1;
                  w_state_nxt = ST_RECV;
               end
            end
            ST_RECV: begin
               if (Vld_in) begin
                  // Early strobe: abandon this word and align to the new frame.
                  w_frmerr_nxt = 1'b1;
                  w_locked_nxt = 1'b0;
                  w_sign_nxt   = ISin;
                  w_slot_nxt   = '0;
                  w_clr        = 1'b1;
               end else begin
                  w_shift = 1'b1;
                  if (r_slot == LAST_SLOT) begin
                     w_load      = 1'b1;
                     w_dvld_nxt  = 1'b1;
                     w_slot_nxt  = '0;
                     w_state_nxt = ST_CHECK;
                  end else begin
                     w_slot_nxt = r_slot + slot_t'(1);
                  end
               end
            end
            ST_CHECK: begin
               if (Vld_in) begin
                  w_locked_nxt = 1'b1;
                  w_sign_nxt   = ISin;
                  w_slot_nxt   = '0;
                  w_clr        = 1'b1;
                  w_state_nxt  = ST_RECV;
               end else begin
                  w_frmerr_nxt = 1'b1;
                  w_locked_nxt = 1'b0;
                  w_state_nxt  = ST_HUNT;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_slot_nxt  = '0;
            end
         endcase
      end
   end

   // Control state and one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_sign_hold <= 1'b0;
         Dvld        <= 1'b0;
         FrmErr      <= 1'b0;
         Locked      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_slot      <= w_slot_nxt;
         r_sign_hold <= w_sign_nxt;
         Dvld        <= w_dvld_nxt;
         FrmErr      <= w_frmerr_nxt;
         Locked      <= w_locked_nxt;
      end
   end

   // Output word and sign update only when a complete frame closes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Dout <= '0;
         Sout <= 1'b0;
      end else if (w_load) begin
         Dout <= w_word_nxt;
         Sout <= r_sign_hold;
      end
   end

endmodule

// File: tb/tb_nco_phase_deserializer.sv
// Bench for nco_phase_deserializer: directed framing scenarios followed by
// randomized frame traffic, all compared cycle by cycle with a frame-level
// reference model.
module tb_nco_phase_deserializer;
   import nco_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               En;
   logic               Vld_in;
   logic [CHUNK_W-1:0] Ain;
   logic               ISin;
   logic [OUT_W-1:0]   Dout;
   logic               Sout;
   logic               Dvld;
   logic               FrmErr;
   logic               Locked;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   nco_phase_deserializer dut (
      .clk    (clk),
      .rst    (rst),
      .En     (En),
      .Vld_in (Vld_in),
      .Ain    (Ain),
      .ISin   (ISin),
      .Dout   (Dout),
      .Sout   (Sout),
      .Dvld   (Dvld),
      .FrmErr (FrmErr),
      .Locked (Locked)
   );

   // Reference model. m_pos: -2 disabled, -1 waiting for a strobe,
   // 0..NSLOT-1 index of the next expected chunk, NSLOT next strobe due.
   int               m_pos;
   int unsigned      m_acc;
   bit               m_sign;
   logic [OUT_W-1:0] m_dout;
   bit               m_sout, m_dvld, m_frmerr, m_locked;

   task automatic model_reset();
      m_pos = -2; m_acc = 0; m_sign = 1'b0;
      m_dout = '0; m_sout = 1'b0; m_dvld = 1'b0; m_frmerr = 1'b0; m_locked = 1'b0;
   endtask

   task automatic model_step(bit en, bit vld, logic [CHUNK_W-1:0] ain, bit is);
      m_dvld = 1'b0;
      m_frmerr = 1'b0;
      if (!en) begin
         m_pos = -2;
         m_locked = 1'b0;
      end else if (m_pos == -2) begin
         m_pos = -1;
      end else if (vld) begin
         if (m_pos == NSLOT) m_locked = 1'b1;
         else if (m_pos >= 0) begin
            m_frmerr = 1'b1;
            m_locked = 1'b0;
         end
         m_sign = is;
         m_acc = 0;
         m_pos = 0;
      end else if (m_pos == NSLOT) begin
         m_frmerr = 1'b1;
         m_locked = 1'b0;
         m_pos = -1;
      end else if (m_pos >= 0) begin
         m_acc = m_acc + ((32'(ain)) << (CHUNK_W * m_pos));
         m_pos++;
         if (m_pos == NSLOT) begin
            m_dout = OUT_W'(m_acc);
            m_sout = m_sign;
            m_dvld = 1'b1;
         end
      end
   endtask

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic cyc(bit en, bit vld, logic [CHUNK_W-1:0] ain, bit is);
      En = en; Vld_in = vld; Ain = ain; ISin = is;
      @(posedge clk);
      model_step(en, vld, ain, is);
      #2;
      check("Dvld",   32'(Dvld),   32'(m_dvld));
      check("FrmErr", 32'(FrmErr), 32'(m_frmerr));
      check("Locked", 32'(Locked), 32'(m_locked));
      check("Dout",   32'(Dout),   32'(m_dout));
      check("Sout",   32'(Sout),   32'(m_sout));
      check("excl",   32'(Dvld & FrmErr), 32'd0);
   endtask

   task automatic strobe(bit s);
      cyc(1'b1, 1'b1, CHUNK_W'($urandom), s);
   endtask

   task automatic chunks(logic [OUT_W-1:0] w, int nch);
      logic [OUT_W-1:0] wv;
      wv = w;
      for (int k = 0; k < nch; k++)
         cyc(1'b1, 1'b0, wv[k*CHUNK_W +: CHUNK_W], 1'($urandom));
   endtask

   task automatic send_frame(logic [OUT_W-1:0] w, bit s);
      strobe(s);
      chunks(w, NSLOT);
   endtask

   task automatic idle_cyc(bit en);
      cyc(en, 1'b0, CHUNK_W'($urandom), 1'($urandom));
   endtask

   logic [OUT_W-1:0] cont_w [4] = '{12'h123, 12'h800, 12'hFFF, 12'h000};
   bit               cont_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [OUT_W-1:0] w;
      logic [OUT_W-1:0] prev;
      int               mode;

      rst = 1'b1; En = 1'b0; Vld_in = 1'b0; Ain = '0; ISin = 1'b0;
      model_reset();
      #12;
      check("rst_Dout",   32'(Dout),   32'd0);
      check("rst_Sout",   32'(Sout),   32'd0);
      check("rst_Dvld",   32'(Dvld),   32'd0);
      check("rst_FrmErr", 32'(FrmErr), 32'd0);
      check("rst_Locked", 32'(Locked), 32'd0);
      #6 rst = 1'b0;

      // Leave IDLE, then one isolated frame from HUNT.
      idle_cyc(1'b1);
      send_frame(12'hAFC, 1'b1);
      check("single_Dvld",   32'(Dvld),   32'd1);
      check("single_Dout",   32'(Dout),   32'hAFC);
      check("single_Sout",   32'(Sout),   32'd1);
      check("single_Locked", 32'(Locked), 32'd0);
      check("single_FrmErr", 32'(FrmErr), 32'd0);

      // Missing strobe in the check cycle.
      idle_cyc(1'b1);
      check("miss_FrmErr", 32'(FrmErr), 32'd1);
      check("miss_Locked", 32'(Locked), 32'd0);

      // Back-to-back stream.
      for (int i = 0; i < 4; i++) begin
         send_frame(cont_w[i], cont_s[i]);
         check("cont_Dout", 32'(Dout), 32'(cont_w[i]));
         check("cont_Sout", 32'(Sout), 32'(cont_s[i]));
         check("cont_Locked", 32'(Locked), (i == 0) ? 32'd0 : 32'd1);
      end

      // Early strobe at slot 3, then a clean frame.
      strobe(1'b0);
      chunks(12'h5A5, 3);
      strobe(1'b1);
      check("early_FrmErr", 32'(FrmErr), 32'd1);
      check("early_Locked", 32'(Locked), 32'd0);
      chunks(12'h3C6, NSLOT);
      check("early_Dout", 32'(Dout), 32'h3C6);
      check("early_Sout", 32'(Sout), 32'd1);

      // Enable drop at slot 4.
      prev = Dout;
      strobe(1'b0);
      chunks(12'h9E1, 4);
      for (int i = 0; i < 3; i++) idle_cyc(1'b0);
      check("endrop_Dout",   32'(Dout),   32'(prev));
      check("endrop_Locked", 32'(Locked), 32'd0);
      idle_cyc(1'b1);
      send_frame(12'h471, 1'b0);
      check("reen_Dout", 32'(Dout), 32'h471);
      check("reen_Sout", 32'(Sout), 32'd0);

      // Lock up, then assert reset between clock edges.
      send_frame(12'hD2B, 1'b1);
      check("prerst_Locked", 32'(Locked), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_Dout",   32'(Dout),   32'd0);
      check("arst_Sout",   32'(Sout),   32'd0);
      check("arst_Dvld",   32'(Dvld),   32'd0);
      check("arst_FrmErr", 32'(FrmErr), 32'd0);
      check("arst_Locked", 32'(Locked), 32'd0);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      idle_cyc(1'b1);
      send_frame(12'h0F0, 1'b1);
      check("postrst_Dout", 32'(Dout), 32'h0F0);

      // Randomized frame traffic with occasional faults.
      for (int it = 0; it < 150; it++) begin
         mode = int'($urandom_range(0, 9));
         w = OUT_W'($urandom);
         if (mode <= 6) begin
            send_frame(w, 1'($urandom));
         end else if (mode == 7) begin
            strobe(1'($urandom));
            chunks(w, int'($urandom_range(0, NSLOT - 1)));
         end else if (mode == 8) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cyc(1'b1);
         end else begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cyc(1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
